// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm
//   Miss-service controller between a cache (i_cache/d_cache) and the shared
//   pipelined main memory. On a miss, it latches the block address. It then
//   issues one word read per cycle until the whole block has been requested.
//   Returned words are streamed into the cache data array in request order.
//   The last word also writes the tag array and pulses fill_done.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous reset, active low
//   miss_detected       cache reports a miss this cycle
//   miss_address        byte address that missed
//   memory_data_valid   memory returns one word this cycle (in request order)
//   memory_data         returned word
//   mem_rd_en           memory read request
//   memory_address      byte address of the current request
//   fsm_busy            fill in progress; cache stalls its pipeline
//   write_data_array    write cache_write_data at cache_word_offset
//   write_tag_array     write tag/valid for the latched block
//   cache_word_offset   word index being written
//   cache_write_data    word being written
//   fill_done           one-cycle pulse when the block is complete
module cache_fill_fsm #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8,
    localparam int OFS_W          = $clog2(WORDS_PER_BLOCK)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic                  memory_data_valid,
    input  logic [DATA_WIDTH-1:0] memory_data,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic                  fsm_busy,
    output logic                  write_data_array,
    output logic                  write_tag_array,
    output logic [OFS_W-1:0]      cache_word_offset,
    output logic [DATA_WIDTH-1:0] cache_write_data,
    output logic                  fill_done
);

    // Block address width: byte address minus word offset minus byte-in-word bit.
    localparam int BLK_W = ADDR_WIDTH - OFS_W - 1;
    // Counters carry one extra bit so "all words requested" is representable.
    localparam int CNT_W = OFS_W + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t            state, state_next;
    logic [BLK_W-1:0]  base, base_next;
    logic [CNT_W-1:0]  req_cnt, req_cnt_next;
    logic [CNT_W-1:0]  ret_cnt, ret_cnt_next;

    // The word offset and byte-in-word bits of the miss address select nothing:
    // a fill always starts from word 0 of the block.
    logic unused_miss_low;
    assign unused_miss_low = ^miss_address[OFS_W:0];

    // State register plus the latched block address and the two counters.
    // Everything clears asynchronously. Because all outputs are decoded from
    // state, the strobes drop as soon as reset asserts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            base    <= '0;
            req_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            state   <= state_next;
            base    <= base_next;
            req_cnt <= req_cnt_next;
            ret_cnt <= ret_cnt_next;
        end
    end

    // Next-state and output decode.
    // The request side and the return side run independently inside FILL.
    // A return may land in the same cycle as a request, and both counters
    // then advance. The fill ends on the last return, not the last request.
    always_comb begin
        state_next        = state;
        base_next         = base;
        req_cnt_next      = req_cnt;
        ret_cnt_next      = ret_cnt;
        mem_rd_en         = 1'b0;
        memory_address    = '0;
        fsm_busy          = 1'b0;
        write_data_array  = 1'b0;
        write_tag_array   = 1'b0;
        cache_word_offset = '0;
        cache_write_data  = '0;
        fill_done         = 1'b0;

        case (state)
            IDLE: begin
                if (miss_detected) begin
                    state_next   = FILL;
                    base_next    = miss_address[ADDR_WIDTH-1:OFS_W+1];
                    req_cnt_next = CNT_ZERO;
                    ret_cnt_next = CNT_ZERO;
                end
            end

            FILL: begin
                fsm_busy = 1'b1;

                // req_cnt stops at CNT_FULL, which ends the request burst.
                if (req_cnt < CNT_FULL) begin
                    mem_rd_en      = 1'b1;
                    memory_address = {base, req_cnt[OFS_W-1:0], 1'b0};
                    req_cnt_next   = req_cnt + CNT_ONE;
                end

                cache_word_offset = ret_cnt[OFS_W-1:0];
                cache_write_data  = memory_data;

                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    ret_cnt_next     = ret_cnt + CNT_ONE;
                    if (ret_cnt == CNT_LAST) begin
                        write_tag_array = 1'b1;
                        fill_done       = 1'b1;
                        state_next      = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm
//   Scoreboard bench for cache_fill_fsm. Stimulus tasks push the expected
//   request addresses and data-array writes into queues when a miss is issued.
//   A monitor pops and compares them whenever the DUT strobes mem_rd_en or
//   write_data_array. The memory model answers each request MEM_LAT cycles
//   later, in order, and returns the request address as the data word.
module tb_cache_fill_fsm;

    localparam int AW       = 16;
    localparam int DW       = 16;
    localparam int WPB      = 8;
    localparam int OW       = 3;
    localparam int MEM_LAT  = 4;
    localparam int FILL_LAT = WPB + MEM_LAT;

    logic          clk = 1'b0;
    logic          rst;
    logic          miss_detected;
    logic [AW-1:0] miss_address;
    logic          memory_data_valid;
    logic [DW-1:0] memory_data;
    logic          mem_rd_en;
    logic [AW-1:0] memory_address;
    logic          fsm_busy;
    logic          write_data_array;
    logic          write_tag_array;
    logic [OW-1:0] cache_word_offset;
    logic [DW-1:0] cache_write_data;
    logic          fill_done;

    typedef struct {
        logic [OW-1:0] offset;
        logic [DW-1:0] data;
        bit            last;
    } wr_exp_t;

    wr_exp_t       wr_q[$];
    logic [AW-1:0] req_q[$];
    logic [AW-1:0] mem_addr_q[$];
    int            mem_due_q[$];

    int n_checks    = 0;
    int n_fail      = 0;
    int cyc         = 0;
    int busy_cnt    = 0;
    int done_seen   = 0;
    int done_cyc    = 0;
    int writes_seen = 0;
    bit stray_valid = 1'b0;

    cache_fill_fsm #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .WORDS_PER_BLOCK (WPB)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .mem_rd_en         (mem_rd_en),
        .memory_address    (memory_address),
        .fsm_busy          (fsm_busy),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .cache_word_offset (cache_word_offset),
        .cache_write_data  (cache_write_data),
        .fill_done         (fill_done)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Cycle counter shared by stimulus, memory model and monitor.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Pipelined in-order memory: requests are seen mid-cycle and answered
    // MEM_LAT cycles later. The answer is driven just after the clock edge.
    // stray_valid injects a return that no request asked for.
    initial begin
        memory_data_valid = 1'b0;
        memory_data       = '0;
        forever begin
            @(negedge clk);
            if (mem_rd_en === 1'b1) begin
                mem_addr_q.push_back(memory_address);
                mem_due_q.push_back(cyc + MEM_LAT);
            end
            @(posedge clk);
            #1;
            if (mem_due_q.size() > 0 && mem_due_q[0] == cyc) begin
                memory_data_valid = 1'b1;
                memory_data       = mem_addr_q.pop_front();
                void'(mem_due_q.pop_front());
            end else if (stray_valid) begin
                memory_data_valid = 1'b1;
                memory_data       = 16'hDEAD;
            end else begin
                memory_data_valid = 1'b0;
                memory_data       = '0;
            end
        end
    end

    // Monitor: compares every request and every data write against the
    // scoreboard queues. Any request or write with nothing queued is a failure.
    initial begin
        wr_exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (fsm_busy === 1'b1) busy_cnt++;
                if (mem_rd_en === 1'b1) begin
                    if (req_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_req: got addr 0x%0h, expected no request (cycle %0d)",
                                 memory_address, cyc);
                    end else begin
                        checkOutput("req_addr", 32'(memory_address), 32'(req_q.pop_front()));
                    end
                end
                if (write_data_array === 1'b1) begin
                    if (wr_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_write: got offset %0d data 0x%0h, expected no write (cycle %0d)",
                                 cache_word_offset, cache_write_data, cyc);
                    end else begin
                        e = wr_q.pop_front();
                        checkOutput("wr_offset", 32'(cache_word_offset), 32'(e.offset));
                        checkOutput("wr_data", 32'(cache_write_data), 32'(e.data));
                        checkOutput("wr_tag", 32'(write_tag_array), 32'(e.last));
                        checkOutput("wr_fill_done", 32'(fill_done), 32'(e.last));
                    end
                    writes_seen++;
                end else begin
                    checkOutput("tag_or_done_without_write",
                                32'({write_tag_array, fill_done}), 32'(0));
                end
                if (fill_done === 1'b1) begin
                    done_seen++;
                    done_cyc = cyc;
                end
            end
        end
    end

    // Expected requests and writes for one block fill starting at addr.
    task automatic pushFill(input logic [AW-1:0] addr);
        logic [AW-1:0] blk;
        blk = addr & 16'hFFF0;
        for (int k = 0; k < WPB; k++) begin
            req_q.push_back(blk + AW'(2 * k));
            wr_q.push_back('{offset: OW'(k), data: DW'(blk + AW'(2 * k)), last: (k == WPB - 1)});
        end
    endtask

    // Issue a miss and wait (bounded) for its fill_done.
    // When hold is set, miss_detected stays high through the whole fill.
    task automatic applyStimulus(input logic [AW-1:0] addr, input bit hold);
        int start_done;
        int miss_cyc;
        bit got;
        @(posedge clk);
        #1;
        miss_detected = 1'b1;
        miss_address  = addr;
        miss_cyc      = cyc;
        busy_cnt      = 0;
        start_done    = done_seen;
        pushFill(addr);
        if (!hold) begin
            @(posedge clk);
            #1;
            miss_detected = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < FILL_LAT + 20 && !got; i++) begin
            @(negedge clk);
            #1;
            if (done_seen != start_done) got = 1'b1;
        end
        miss_detected = 1'b0;
        checkOutput("fill_completed", 32'(got), 32'(1));
        checkOutput("fill_latency", 32'(done_cyc - miss_cyc), 32'(FILL_LAT));
        checkOutput("busy_cycles", 32'(busy_cnt), 32'(FILL_LAT));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'(0));
        checkOutput({tag, "_memory_address"}, 32'(memory_address), 32'(0));
        checkOutput({tag, "_fsm_busy"}, 32'(fsm_busy), 32'(0));
        checkOutput({tag, "_write_data_array"}, 32'(write_data_array), 32'(0));
        checkOutput({tag, "_write_tag_array"}, 32'(write_tag_array), 32'(0));
        checkOutput({tag, "_cache_word_offset"}, 32'(cache_word_offset), 32'(0));
        checkOutput({tag, "_cache_write_data"}, 32'(cache_write_data), 32'(0));
        checkOutput({tag, "_fill_done"}, 32'(fill_done), 32'(0));
    endtask

    // Hard stop in case something upstream of the bounded waits locks up.
    initial begin
        repeat (20000) @(posedge clk);
        $display("[TB] FAIL watchdog: got no end of test, expected $finish within 20000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start;
        bit got;
        rst           = 1'b0;
        miss_detected = 1'b0;
        miss_address  = '0;

        // Reset held: every output quiet.
        #3;
        checkAllZero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Idle after reset with no miss: nothing moves.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checkOutput("idle_activity",
                        32'({mem_rd_en, fsm_busy, write_data_array, write_tag_array, fill_done}),
                        32'(0));
        end

        // Plain fill from the middle of a block.
        $display("[TB] miss at 0x1812");
        applyStimulus(16'h1812, 1'b0);

        // miss_detected held high through FILL must not retrigger.
        $display("[TB] held miss at 0x0413");
        applyStimulus(16'h0413, 1'b1);
        repeat (2) @(negedge clk);

        // Stray return while idle: no write, still idle.
        stray_valid = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("stray_valid_seen_by_dut", 32'(memory_data_valid), 32'(1));
        checkOutput("stray_no_write", 32'(write_data_array), 32'(0));
        checkOutput("stray_not_busy", 32'(fsm_busy), 32'(0));
        stray_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Back-to-back: second miss in the cycle right after fill_done.
        $display("[TB] back-to-back misses 0x0001 then 0x1913");
        applyStimulus(16'h0001, 1'b0);
        applyStimulus(16'h1913, 1'b0);
        repeat (2) @(negedge clk);

        // Reset in the middle of a fill, just after the third return.
        $display("[TB] reset mid-fill");
        @(posedge clk);
        #1;
        miss_detected = 1'b1;
        miss_address  = 16'h2A36;
        pushFill(16'h2A36);
        @(posedge clk);
        #1;
        miss_detected = 1'b0;
        start = writes_seen;
        got   = 1'b0;
        for (int i = 0; i < FILL_LAT + 20 && !got; i++) begin
            @(negedge clk);
            #1;
            if (writes_seen - start >= 3) got = 1'b1;
        end
        checkOutput("third_return_seen", 32'(got), 32'(1));
        checkOutput("busy_before_reset", 32'(fsm_busy), 32'(1));
        rst = 1'b0;
        #1;
        checkAllZero("reset_mid_fill");
        req_q.delete();
        wr_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        // Stale returns for the aborted fill arrive here; the monitor flags any write.
        repeat (8) @(negedge clk);
        #1;
        checkOutput("idle_after_stale_returns", 32'(fsm_busy), 32'(0));

        // Clean fill after the aborted one.
        $display("[TB] miss at 0x0812 after reset");
        applyStimulus(16'h0812, 1'b0);
        repeat (3) @(negedge clk);

        checkOutput("req_queue_drained", 32'(req_q.size()), 32'(0));
        checkOutput("write_queue_drained", 32'(wr_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
